register_file_sb: RTL and testbench
===================================

Name: register_file_sb

Overview:
- Parametrised successor of the core's 64-bit register file; sits in the ID/WB stages of each CMP core.
- Provides a lane-masked write port and two forwarding read ports, with configurable width, depth and lane size.
- Adds a pending-write scoreboard (reserve on long-latency issue, clear on writeback) that flags read hazards.
- Adds a sticky illegal-PPP error flag.

Parameters:
- DATA_WIDTH, 64, register width; must be an even multiple of LANE_WIDTH.
- LANE_WIDTH, 8, subfield width in bits.
- ADDR_WIDTH, 5, register address width.
- DEPTH, 32, number of registers; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wen  in  1  write enable.
- wr_addr  in  ADDR_WIDTH  write address.
- data_in  in  DATA_WIDTH  write data; big-endian, bit 0 is MSB.
- PPP_sel  in  3  participation select.
- rd_addr_0, rd_addr_1  in  ADDR_WIDTH  read addresses.
- rd_en_0, rd_en_1  in  1  read port in use; qualifies hazard only.
- data_out_0, data_out_1  out  DATA_WIDTH  read data, combinational.
- resv_en  in  1  reserve (mark pending) resv_addr.
- resv_addr  in  ADDR_WIDTH  register to reserve.
- hazard_0, hazard_1  out  1  read port targets a pending register.
- resv_err  out  1  registered one-cycle pulse: reserve to an already-pending register.
- err_clr  in  1  clears err_ppp.
- err_ppp  out  1  sticky: a write was attempted with an invalid PPP_sel.

Behaviour:
- Lanes: NL = DATA_WIDTH/LANE_WIDTH; lane k = bits [k*LANE_WIDTH : (k+1)*LANE_WIDTH-1]; lane 0 holds the MSB.
- Lane mask from PPP_sel:
  - 000: all lanes.
  - 001: lanes 0..NL/2-1 (upper half).
  - 010: lanes NL/2..NL-1 (lower half).
  - 011: even lanes.
  - 100: odd lanes.
  - 101-111: invalid; empty mask.
- Write: on the rising clk edge with wen=1 and wr_addr!=0, masked lanes update and other lanes keep their value. Data is visible in the array the next cycle.
- Register 0 always reads 0. wr_addr >= DEPTH is ignored.
- Invalid PPP_sel with wen=1: no write and no clear of the pending bit. err_ppp sets on the next edge and holds until err_clr=1 or reset. If err_clr and a new invalid write occur together, set wins.
- Read, per port: data_out = array[rd_addr]. With forwarding on, if wen=1, wr_addr==rd_addr and wr_addr!=0, masked lanes come from data_in and unmasked lanes from the array. No latches; every bit is driven every cycle.
- Scoreboard: pend[DEPTH] bits.
  - Edge with resv_en=1 and resv_addr!=0: pend[resv_addr] <= 1.
  - Edge with a valid write (wen=1, legal PPP, wr_addr!=0): pend[wr_addr] <= 0. Any legal partial mask clears the bit.
  - Same edge, same address for reserve and write: pend stays 1 (reserve wins).
  - resv_en to a register already pending and not being cleared that edge: pend stays 1; resv_err pulses high for one cycle after the edge.
  - resv_addr==0 is ignored.
- hazard_n = rd_en_n & pend[rd_addr_n] & ~(same-cycle full-mask write to rd_addr_n, forwarding on only). rd_addr 0 never hazards.
- Reset asserted (any time, mid-operation included): array, pend, err_ppp and resv_err cleared immediately. Outputs read 0 while reset is held. The first write is accepted on the first edge after deassertion.

Optional Feature:
- Macro: RF_FWD_EN.
- Defined: same-cycle write-to-read forwarding and hazard suppression as described above.
- Undefined: data_out always equals the array contents (pre-write value). hazard_n ignores same-cycle writes, so a full-mask write does not suppress hazard in the cycle it occurs. Pending clear timing is unchanged.

Test Plan:
- Reset low 2 cycles, release; read r5 and r0 -> both 0; hazards 0; err_ppp 0.
- Write r3 = 0x0011223344556677 mode 000, then mode 011 with 0xFFFF…FF -> r3 reads 0xFF11FF33FF55FF77. Repeat with mode 100 -> r3 reads 0xFFFFFFFFFFFFFFFF.
- RF_FWD_EN defined; r4 = 0x1111111111111111; same cycle write r4 mode 010 with 0xAAAA…AA and read r4 on port 1 -> data_out_1 = 0x11111111AAAAAAAA. Undefined -> 0x1111111111111111.
- resv r7; next cycle rd_addr_0 = 7, rd_en_0 = 1 -> hazard_0 = 1. Reserve r7 again -> resv_err pulses 1 cycle. Write r7 mode 000 -> hazard_0 = 0 after the edge.
- Write r9 with PPP_sel = 110 -> r9 unchanged; err_ppp = 1 after the edge and held; err_clr = 1 -> err_ppp = 0 next cycle.
- Reserve and write r2 on the same edge -> pend[2] remains 1. Assert reset mid-sequence -> hazards and err_ppp drop to 0 immediately; r2 reads 0.

Source files
------------

// File: rtl/register_file_sb_if.sv
// Bus interface of register_file_sb: write port, two read ports, scoreboard
// reserve port and error flags. The master modport drives requests; the slave modport is the register file.
interface register_file_sb_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) ();
    logic                  wen;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [2:0]            PPP_sel;
    logic [ADDR_WIDTH-1:0] rd_addr_0;
    logic [ADDR_WIDTH-1:0] rd_addr_1;
    logic                  rd_en_0;
    logic                  rd_en_1;
    logic [DATA_WIDTH-1:0] data_out_0;
    logic [DATA_WIDTH-1:0] data_out_1;
    logic                  resv_en;
    logic [ADDR_WIDTH-1:0] resv_addr;
    logic                  hazard_0;
    logic                  hazard_1;
    logic                  resv_err;
    logic                  err_clr;
    logic                  err_ppp;

    modport master (
        output wen, wr_addr, data_in, PPP_sel, rd_addr_0, rd_addr_1,
               rd_en_0, rd_en_1, resv_en, resv_addr, err_clr,
        input  data_out_0, data_out_1, hazard_0, hazard_1, resv_err, err_ppp
    );

    modport slave (
        input  wen, wr_addr, data_in, PPP_sel, rd_addr_0, rd_addr_1,
               rd_en_0, rd_en_1, resv_en, resv_addr, err_clr,
        output data_out_0, data_out_1, hazard_0, hazard_1, resv_err, err_ppp
    );
endinterface

// File: rtl/register_file_sb.sv
// Lane-masked register file with two read ports, a pending-write scoreboard and a sticky PPP error.
// Optional macro RF_FWD_EN enables same-cycle write-to-read forwarding and hazard suppression.
module register_file_sb #(
    parameter int DATA_WIDTH = 64,
    parameter int LANE_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                clk,
    input  logic                reset,
    register_file_sb_if.slave   bus
);
    localparam int NL = DATA_WIDTH / LANE_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    // Lane 0 is the most significant lane of the word.
    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [2:0] sel);
        logic [NL-1:0]         lanes;
        logic [DATA_WIDTH-1:0] m;
        lanes = '0;
        m     = '0;
        for (int k = 0; k < NL; k++) begin
            case (sel)
                3'b000:  lanes[k] = 1'b1;
                3'b001:  lanes[k] = (k < NL / 2);
                3'b010:  lanes[k] = (k >= NL / 2);
                3'b011:  lanes[k] = (k % 2 == 0);
                3'b100:  lanes[k] = (k % 2 == 1);
                default: lanes[k] = 1'b0;
            endcase
        end
        for (int k = 0; k < NL; k++) begin
            m[DATA_WIDTH-1-k*LANE_WIDTH -: LANE_WIDTH] = {LANE_WIDTH{lanes[k]}};
        end
        return m;
    endfunction

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_L) && (a != '0);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic                  err_ppp_q, err_ppp_d;
    logic                  resv_err_q, resv_err_d;

    logic [DATA_WIDTH-1:0] wr_mask, wr_word_d;
    logic                  ppp_legal, wr_ok, full_wr, resv_ok;
    logic [DATA_WIDTH-1:0] arr_0, arr_1, rd_0, rd_1;
    logic                  fwd_0, fwd_1, hz_0, hz_1;

    always_comb begin
        wr_mask   = lane_mask(bus.PPP_sel);
        ppp_legal = (bus.PPP_sel <= 3'b100);
        wr_ok     = bus.wen && ppp_legal && addr_ok(bus.wr_addr);
        full_wr   = wr_ok && (bus.PPP_sel == 3'b000);
        resv_ok   = bus.resv_en && addr_ok(bus.resv_addr);
        wr_word_d = (mem_q[bus.wr_addr] & ~wr_mask) | (bus.data_in & wr_mask);
    end

    // Reserve is applied after the writeback clear so it wins on a shared address.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok)   pend_d[bus.wr_addr]   = 1'b0;
        if (resv_ok) pend_d[bus.resv_addr] = 1'b1;
        resv_err_d = resv_ok && pend_q[bus.resv_addr] &&
                     !(wr_ok && (bus.wr_addr == bus.resv_addr));
        err_ppp_d  = (bus.wen && !ppp_legal) ? 1'b1 :
                     (bus.err_clr ? 1'b0 : err_ppp_q);
    end

    always_comb begin
        arr_0 = addr_ok(bus.rd_addr_0) ? mem_q[bus.rd_addr_0] : '0;
        arr_1 = addr_ok(bus.rd_addr_1) ? mem_q[bus.rd_addr_1] : '0;
`ifdef RF_FWD_EN
        fwd_0 = wr_ok && (bus.wr_addr == bus.rd_addr_0);
        fwd_1 = wr_ok && (bus.wr_addr == bus.rd_addr_1);
`else
        fwd_0 = 1'b0;
        fwd_1 = 1'b0;
`endif
        rd_0 = fwd_0 ? ((arr_0 & ~wr_mask) | (bus.data_in & wr_mask)) : arr_0;
        rd_1 = fwd_1 ? ((arr_1 & ~wr_mask) | (bus.data_in & wr_mask)) : arr_1;
        hz_0 = bus.rd_en_0 && addr_ok(bus.rd_addr_0) && pend_q[bus.rd_addr_0] &&
               !(fwd_0 && full_wr);
        hz_1 = bus.rd_en_1 && addr_ok(bus.rd_addr_1) && pend_q[bus.rd_addr_1] &&
               !(fwd_1 && full_wr);
    end

    // Forwarded data is masked off while reset is held.
    assign bus.data_out_0 = reset ? rd_0 : '0;
    assign bus.data_out_1 = reset ? rd_1 : '0;
    assign bus.hazard_0   = reset & hz_0;
    assign bus.hazard_1   = reset & hz_1;
    assign bus.resv_err   = resv_err_q;
    assign bus.err_ppp    = err_ppp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pend_q     <= '0;
            err_ppp_q  <= 1'b0;
            resv_err_q <= 1'b0;
        end else begin
            if (wr_ok) mem_q[bus.wr_addr] <= wr_word_d;
            pend_q     <= pend_d;
            err_ppp_q  <= err_ppp_d;
            resv_err_q <= resv_err_d;
        end
    end
endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: stimulus queues expected values, a negedge monitor compares them.
module tb_register_file_sb;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic reset;

    register_file_sb_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

    register_file_sb #(
        .DATA_WIDTH(64), .LANE_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // kind: 0 data_out_0, 1 data_out_1, 2 hazard_0, 3 hazard_1, 4 resv_err, 5 err_ppp
    task automatic expect_v(input int kind, input logic [63:0] e, input string n);
        chk_t c;
        c.kind = kind;
        c.exp  = e;
        c.name = n;
        sb.push_back(c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        chk_t        c;
        logic [63:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            case (c.kind)
                0:       act = bus.data_out_0;
                1:       act = bus.data_out_1;
                2:       act = {63'd0, bus.hazard_0};
                3:       act = {63'd0, bus.hazard_1};
                4:       act = {63'd0, bus.resv_err};
                default: act = {63'd0, bus.err_ppp};
            endcase
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    initial begin
        reset         = 1'b0;
        bus.wen       = 1'b0;
        bus.wr_addr   = '0;
        bus.data_in   = '0;
        bus.PPP_sel   = 3'b000;
        bus.rd_addr_0 = '0;
        bus.rd_addr_1 = '0;
        bus.rd_en_0   = 1'b0;
        bus.rd_en_1   = 1'b0;
        bus.resv_en   = 1'b0;
        bus.resv_addr = '0;
        bus.err_clr   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        bus.rd_addr_0 = 5'd5; bus.rd_addr_1 = 5'd0;
        bus.rd_en_0 = 1'b1; bus.rd_en_1 = 1'b1;
        expect_v(0, 64'd0, "reset_rd5");
        expect_v(2, 64'd0, "reset_hz0");
        expect_v(5, 64'd0, "reset_err");
        step();
        reset = 1'b1;
        expect_v(0, 64'd0, "post_rd5");
        expect_v(1, 64'd0, "post_rd0");
        expect_v(3, 64'd0, "post_hz1");
        expect_v(4, 64'd0, "post_resv_err");

        // lane masks on r3
        bus.rd_en_0 = 1'b0; bus.rd_en_1 = 1'b0;
        bus.wen = 1'b1; bus.wr_addr = 5'd3; bus.PPP_sel = 3'b000;
        bus.data_in = 64'h0011_2233_4455_6677;
        step();
        bus.PPP_sel = 3'b011; bus.data_in = ONES;
        step();
        bus.wen = 1'b0; bus.rd_addr_0 = 5'd3;
        expect_v(0, 64'hFF11_FF33_FF55_FF77, "r3_even");
        step();
        bus.wen = 1'b1; bus.PPP_sel = 3'b100;
        step();
        bus.wen = 1'b0;
        expect_v(0, ONES, "r3_odd");

        // forwarding on r4
        bus.wen = 1'b1; bus.wr_addr = 5'd4; bus.PPP_sel = 3'b000;
        bus.data_in = 64'h1111_1111_1111_1111;
        step();
        bus.PPP_sel = 3'b010; bus.data_in = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.rd_addr_1 = 5'd4;
`ifdef RF_FWD_EN
        expect_v(1, 64'h1111_1111_AAAA_AAAA, "r4_fwd");
`else
        expect_v(1, 64'h1111_1111_1111_1111, "r4_nofwd");
`endif
        step();
        bus.wen = 1'b0;
        expect_v(1, 64'h1111_1111_AAAA_AAAA, "r4_after");

        // scoreboard on r7
        bus.resv_en = 1'b1; bus.resv_addr = 5'd7;
        step();
        bus.resv_en = 1'b0; bus.rd_addr_0 = 5'd7; bus.rd_en_0 = 1'b1;
        expect_v(2, 64'd1, "r7_hazard");
        expect_v(4, 64'd0, "r7_no_err");
        bus.resv_en = 1'b1;
        step();
        bus.resv_en = 1'b0;
        expect_v(4, 64'd1, "r7_resv_err");
        expect_v(2, 64'd1, "r7_hazard_held");
        step();
        expect_v(4, 64'd0, "r7_err_pulse_end");
        bus.wen = 1'b1; bus.wr_addr = 5'd7; bus.PPP_sel = 3'b000; bus.data_in = 64'h7;
`ifdef RF_FWD_EN
        expect_v(2, 64'd0, "r7_hz_suppressed");
`else
        expect_v(2, 64'd1, "r7_hz_not_suppressed");
`endif
        step();
        bus.wen = 1'b0;
        expect_v(2, 64'd0, "r7_hz_cleared");
        expect_v(0, 64'h7, "r7_data");

        // partial write clears pending on r8, but never suppresses in-cycle
        bus.resv_en = 1'b1; bus.resv_addr = 5'd8;
        step();
        bus.resv_en = 1'b0; bus.rd_addr_1 = 5'd8; bus.rd_en_1 = 1'b1;
        bus.wen = 1'b1; bus.wr_addr = 5'd8; bus.PPP_sel = 3'b001; bus.data_in = ONES;
        expect_v(3, 64'd1, "r8_partial_hz");
        step();
        bus.wen = 1'b0;
        expect_v(3, 64'd0, "r8_cleared");
        expect_v(1, 64'hFFFF_FFFF_0000_0000, "r8_upper");

        // invalid PPP on r9
        bus.wen = 1'b1; bus.wr_addr = 5'd9; bus.PPP_sel = 3'b000;
        bus.data_in = 64'h0123_4567_89AB_CDEF;
        bus.resv_en = 1'b1; bus.resv_addr = 5'd9;
        step();
        bus.resv_en = 1'b0;
        bus.PPP_sel = 3'b110; bus.data_in = ONES; bus.rd_addr_0 = 5'd9;
        expect_v(0, 64'h0123_4567_89AB_CDEF, "r9_bad_noforward");
        step();
        bus.wen = 1'b0;
        expect_v(0, 64'h0123_4567_89AB_CDEF, "r9_unchanged");
        expect_v(5, 64'd1, "err_set");
        expect_v(2, 64'd1, "r9_pend_kept");
        step();
        expect_v(5, 64'd1, "err_held");
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        expect_v(5, 64'd0, "err_cleared");
        bus.err_clr = 1'b1; bus.wen = 1'b1; bus.PPP_sel = 3'b111;
        step();
        bus.err_clr = 1'b0; bus.wen = 1'b0;
        expect_v(5, 64'd1, "err_set_wins");

        // r0 ignores writes and reserves
        bus.wen = 1'b1; bus.wr_addr = 5'd0; bus.PPP_sel = 3'b000; bus.data_in = ONES;
        bus.resv_en = 1'b1; bus.resv_addr = 5'd0;
        step();
        bus.wen = 1'b0; bus.resv_en = 1'b0;
        bus.rd_addr_0 = 5'd0; bus.rd_en_0 = 1'b1;
        expect_v(0, 64'd0, "r0_zero");
        expect_v(2, 64'd0, "r0_no_hazard");

        // reserve and write r2 together; reserve wins
        bus.resv_en = 1'b1; bus.resv_addr = 5'd2;
        bus.wen = 1'b1; bus.wr_addr = 5'd2; bus.data_in = 64'h5555_5555_5555_5555;
        step();
        bus.resv_en = 1'b0; bus.wen = 1'b0;
        bus.rd_addr_1 = 5'd2; bus.rd_en_1 = 1'b1;
        expect_v(3, 64'd1, "r2_pend_kept");
        expect_v(1, 64'h5555_5555_5555_5555, "r2_data");
        expect_v(4, 64'd0, "r2_no_resv_err");
        expect_v(5, 64'd1, "err_still_set");

        // asynchronous reset mid-cycle
        step();
        #1;
        reset = 1'b0;
        expect_v(3, 64'd0, "rst_hz1");
        expect_v(5, 64'd0, "rst_err");
        expect_v(1, 64'd0, "rst_r2");
        step();
        reset = 1'b1;
        bus.rd_addr_0 = 5'd3;
        expect_v(0, 64'd0, "rst_r3");
        expect_v(1, 64'd0, "rst_r2_after");
        bus.wen = 1'b1; bus.wr_addr = 5'd6; bus.data_in = 64'hDEAD_BEEF_CAFE_F00D;
        step();
        bus.wen = 1'b0; bus.rd_addr_0 = 5'd6;
        expect_v(0, 64'hDEAD_BEEF_CAFE_F00D, "first_write");
        step();
        step();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
